sprite_compositor: RTL and testbench

- Parametrised, pipelined successor to the combinational circle colour mapper.
- Composites NUM_OBJ circular sprites (players, bombs, blasts) over a background colour for each VGA pixel.
- Adds per-object colour, enable and blink, registered RGB output, a per-pixel winning-object ID, and a per-frame overlap (collision) report for game logic.
- Sits between the sprite-state logic and the VGA controller; DrawX/DrawY/pixel_valid come from the VGA controller and are delayed to match the pipeline.

---
 rtl/sprite_pkg.sv | 30 +++
 rtl/circle_hit.sv | 67 ++++++
 rtl/sprite_compositor.sv | 132 +++++++++++++
 tb/tb_sprite_compositor.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared widths, types and helpers for the sprite compositor
package sprite_pkg;

    localparam int COORD_W = 10;
    localparam int COLOR_W = 8;
    localparam int ID_W    = 3;

    localparam logic [ID_W-1:0] BG_ID = '1;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] s;
        rgb_t               color;
        logic               en;
        logic               blink;
    } obj_t;

    // True when at least two bits are set: clearing the lowest set bit leaves something.
    function automatic logic multi_hit(input logic [15:0] v);
        return (v & (v - 16'd1)) != 16'd0;
    endfunction

endpackage

// File: rtl/circle_hit.sv
// rtl/circle_hit.sv - S1/S2 datapath for one circular sprite: offset, squared distance, registered hit
module circle_hit #(
    parameter int COORD_W = 10
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    input  logic [COORD_W-1:0] obj_x,
    input  logic [COORD_W-1:0] obj_y,
    input  logic [COORD_W-1:0] obj_s,
    input  logic               obj_en,
    input  logic               obj_blink,
    input  logic               blink_phase,
    output logic               hit_q
);
    import sprite_pkg::*;

    localparam int DW = COORD_W + 1;
    localparam int SW = 2 * COORD_W + 2;

    logic signed [DW-1:0]   dx_d, dx_q, dy_d, dy_q;
    logic [COORD_W-1:0]     r_d, r_q;
    logic                   en_d, en_q, blink_d, blink_q;
    logic signed [SW-1:0]   dx_ext, dy_ext, sq_x, sq_y;
    logic [2*COORD_W-1:0]   r_sq;
    logic [SW:0]            dist_sq;
    logic                   hit_d;

    always_comb begin
        dx_d    = {1'b0, draw_x} - {1'b0, obj_x};
        dy_d    = {1'b0, draw_y} - {1'b0, obj_y};
        r_d     = obj_s;
        en_d    = obj_en;
        blink_d = obj_blink;
    end

    // Full-width squares so the largest offsets cannot wrap into a false hit.
    always_comb begin
        dx_ext  = {{(SW-DW){dx_q[DW-1]}}, dx_q};
        dy_ext  = {{(SW-DW){dy_q[DW-1]}}, dy_q};
        sq_x    = dx_ext * dx_ext;
        sq_y    = dy_ext * dy_ext;
        r_sq    = {{COORD_W{1'b0}}, r_q} * {{COORD_W{1'b0}}, r_q};
        dist_sq = {1'b0, sq_x} + {1'b0, sq_y};
        hit_d   = en_q & ~(blink_q & blink_phase) & (dist_sq <= {3'b000, r_sq});
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dx_q    <= '0;
            dy_q    <= '0;
            r_q     <= '0;
            en_q    <= 1'b0;
            blink_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            r_q     <= r_d;
            en_q    <= en_d;
            blink_q <= blink_d;
            hit_q   <= hit_d;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - 3-stage circular sprite compositor with blink, priority mux and overlap report
module sprite_compositor #(
    parameter int                     NUM_OBJ      = 4,
    parameter int                     COORD_W      = 10,
    parameter int                     COLOR_W      = 8,
    parameter int                     BLINK_FRAMES = 8,
    parameter logic [3*COLOR_W-1:0]   BG_COLOR     = '0
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          frame_start,
    input  logic                          pixel_valid,
    input  logic [COORD_W-1:0]            DrawX,
    input  logic [COORD_W-1:0]            DrawY,
    input  logic [NUM_OBJ*COORD_W-1:0]    obj_x,
    input  logic [NUM_OBJ*COORD_W-1:0]    obj_y,
    input  logic [NUM_OBJ*COORD_W-1:0]    obj_s,
    input  logic [NUM_OBJ*3*COLOR_W-1:0]  obj_color,
    input  logic [NUM_OBJ-1:0]            obj_en,
    input  logic [NUM_OBJ-1:0]            obj_blink,
    output logic [COLOR_W-1:0]            Red,
    output logic [COLOR_W-1:0]            Green,
    output logic [COLOR_W-1:0]            Blue,
    output logic                          pix_valid_out,
    output logic [$clog2(NUM_OBJ):0]      hit_id,
    output logic [NUM_OBJ-1:0]            overlap_mask
);
    import sprite_pkg::*;

    localparam int ID_W  = $clog2(NUM_OBJ) + 1;
    localparam int RGB_W = 3 * COLOR_W;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [NUM_OBJ-1:0] hit;
    logic               v1_d, v1_q, v2_d, v2_q;
    logic [FC_W-1:0]    frame_cnt_d, frame_cnt_q;
    logic               blink_phase_d, blink_phase_q;
    logic [RGB_W-1:0]   rgb_d, rgb_q;
    logic [ID_W-1:0]    id_d, id_q;
    logic               pvo_d, pvo_q;
    logic [NUM_OBJ-1:0] acc_d, acc_q, mask_d, mask_q;

    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
        circle_hit #(.COORD_W(COORD_W)) u_hit (
            .Clk         (Clk),
            .Reset       (Reset),
            .draw_x      (DrawX),
            .draw_y      (DrawY),
            .obj_x       (obj_x[i*COORD_W +: COORD_W]),
            .obj_y       (obj_y[i*COORD_W +: COORD_W]),
            .obj_s       (obj_s[i*COORD_W +: COORD_W]),
            .obj_en      (obj_en[i]),
            .obj_blink   (obj_blink[i]),
            .blink_phase (blink_phase_q),
            .hit_q       (hit[i])
        );
    end

    always_comb begin
        v1_d          = pixel_valid;
        v2_d          = v1_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_start) begin
            if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
        end
    end

    // Descending scan so the lowest-index hit is the last writer and wins.
    always_comb begin
        rgb_d = '0;
        id_d  = '1;
        pvo_d = v2_q;
        if (v2_q) begin
            rgb_d = BG_COLOR;
            for (int i = NUM_OBJ - 1; i >= 0; i--) begin
                if (hit[i]) begin
                    rgb_d = obj_color[i*RGB_W +: RGB_W];
                    id_d  = ID_W'(i);
                end
            end
        end
    end

    // The S2 result in the pulse cycle still belongs to the frame being closed.
    always_comb begin
        acc_d  = acc_q;
        mask_d = mask_q;
        if (v2_q && multi_hit(16'(hit))) begin
            acc_d = acc_q | hit;
        end
        if (frame_start) begin
            mask_d = acc_d;
            acc_d  = '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            v1_q          <= 1'b0;
            v2_q          <= 1'b0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            rgb_q         <= '0;
            id_q          <= '1;
            pvo_q         <= 1'b0;
            acc_q         <= '0;
            mask_q        <= '0;
        end else begin
            v1_q          <= v1_d;
            v2_q          <= v2_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            rgb_q         <= rgb_d;
            id_q          <= id_d;
            pvo_q         <= pvo_d;
            acc_q         <= acc_d;
            mask_q        <= mask_d;
        end
    end

    assign {Red, Green, Blue} = rgb_q;
    assign pix_valid_out      = pvo_q;
    assign hit_id             = id_q;
    assign overlap_mask       = mask_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - scoreboard bench for sprite_compositor with directed pixels
module tb_sprite_compositor;
    import sprite_pkg::*;

    localparam int N  = 4;
    localparam int CW = 10;
    localparam int IW = $clog2(N) + 1;

    localparam rgb_t        RED  = '{r: 8'hFF, g: 8'h00, b: 8'h00};
    localparam rgb_t        GRN  = '{r: 8'h00, g: 8'hFF, b: 8'h00};
    localparam rgb_t        BLU  = '{r: 8'h00, g: 8'h00, b: 8'hFF};
    localparam logic [23:0] BGC  = 24'h203040;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              frame_start = 1'b0;
    logic              pixel_valid = 1'b0;
    logic [CW-1:0]     DrawX = '0, DrawY = '0;
    logic [N*CW-1:0]   obj_x = '0, obj_y = '0, obj_s = '0;
    logic [N*24-1:0]   obj_color = '0;
    logic [N-1:0]      obj_en = '0, obj_blink = '0;
    logic [7:0]        Red, Green, Blue;
    logic              pix_valid_out;
    logic [IW-1:0]     hit_id;
    logic [N-1:0]      overlap_mask;

    sprite_compositor #(
        .NUM_OBJ(N), .COORD_W(CW), .COLOR_W(8), .BLINK_FRAMES(2), .BG_COLOR(BGC)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
        .DrawX(DrawX), .DrawY(DrawY), .obj_x(obj_x), .obj_y(obj_y), .obj_s(obj_s),
        .obj_color(obj_color), .obj_en(obj_en), .obj_blink(obj_blink),
        .Red(Red), .Green(Green), .Blue(Blue), .pix_valid_out(pix_valid_out),
        .hit_id(hit_id), .overlap_mask(overlap_mask)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [63:0]   tag;
        int            due;
        logic          is_mask;
        logic          v;
        logic [23:0]   rgb;
        logic [IW-1:0] id;
        logic [N-1:0]  mask;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            n_checks++;
            if (cur.due != cyc) begin
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", cur.tag, cur.due, cyc);
            end else if (cur.is_mask) begin
                if (overlap_mask === cur.mask) n_pass++;
                else $display("FAIL %s: overlap_mask=%b required %b", cur.tag, overlap_mask, cur.mask);
            end else begin
                if (pix_valid_out === cur.v && {Red, Green, Blue} === cur.rgb && hit_id === cur.id) n_pass++;
                else $display("FAIL %s: valid=%b rgb=%h id=%0d required valid=%b rgb=%h id=%0d",
                              cur.tag, pix_valid_out, {Red, Green, Blue}, hit_id, cur.v, cur.rgb, cur.id);
            end
        end
    end

    task automatic exp_px(input logic [63:0] tag, input int lat, input logic v,
                          input logic [23:0] rgb, input int id);
        exp_t e;
        e.tag = tag; e.due = cyc + lat; e.is_mask = 1'b0;
        e.v = v; e.rgb = rgb; e.id = IW'(id); e.mask = '0;
        sb.push_back(e);
    endtask

    task automatic exp_mask(input logic [63:0] tag, input int lat, input logic [N-1:0] m);
        exp_t e;
        e.tag = tag; e.due = cyc + lat; e.is_mask = 1'b1;
        e.v = 1'b0; e.rgb = '0; e.id = '0; e.mask = m;
        sb.push_back(e);
    endtask

    task automatic px(input int x, input int y, input logic v, input logic [23:0] rgb,
                      input int id, input logic [63:0] tag);
        @(posedge Clk); #1;
        DrawX = CW'(x); DrawY = CW'(y); pixel_valid = v;
        exp_px(tag, 3, v, rgb, id);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk); #1;
            pixel_valid = 1'b0;
        end
    endtask

    task automatic pulse(input logic [63:0] tag, input logic [N-1:0] m);
        @(posedge Clk); #1;
        pixel_valid = 1'b0; frame_start = 1'b1;
        exp_mask(tag, 1, m);
        @(posedge Clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic set_obj(input int i, input int x, input int y, input int s,
                           input logic [23:0] c, input logic en, input logic bl);
        obj_x[i*CW +: CW]  = CW'(x);
        obj_y[i*CW +: CW]  = CW'(y);
        obj_s[i*CW +: CW]  = CW'(s);
        obj_color[i*24 +: 24] = c;
        obj_en[i]    = en;
        obj_blink[i] = bl;
    endtask

    task automatic reset_dut();
        @(posedge Clk); #1;
        Reset = 1'b1; pixel_valid = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached with %0d expectations pending", sb.size());
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        exp_px("rst0", 0, 1'b0, 24'h0, -1);
        exp_mask("rst0_msk", 0, '0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        // single object sweep across row 240; inclusive boundary at 310 and 330
        set_obj(0, 320, 240, 10, RED, 1'b1, 1'b0);
        for (int x = 305; x <= 335; x++) begin
            if (x >= 310 && x <= 330) px(x, 240, 1'b1, RED, 0, "sweep");
            else                      px(x, 240, 1'b1, BGC, -1, "sweep_bg");
        end
        px(320, 240, 1'b0, 24'h0, -1, "blank");
        px(320, 240, 1'b1, RED, 0, "unblank");

        // coordinate extremes and zero radius
        idle(4);
        set_obj(0, 0, 0, 1023, RED, 1'b1, 1'b0);
        px(1023, 0, 1'b1, RED, 0, "ext_x");
        px(0, 1023, 1'b1, RED, 0, "ext_y");
        px(723, 723, 1'b1, RED, 0, "ext_diag");
        px(724, 724, 1'b1, BGC, -1, "ext_out");
        px(1023, 1023, 1'b1, BGC, -1, "ext_far");
        idle(4);
        set_obj(0, 1023, 1023, 1023, RED, 1'b1, 1'b0);
        px(0, 1023, 1'b1, RED, 0, "ext_neg");
        idle(4);
        set_obj(0, 50, 60, 0, RED, 1'b1, 1'b0);
        px(50, 60, 1'b1, RED, 0, "r0_ctr");
        px(51, 60, 1'b1, BGC, -1, "r0_x");
        px(50, 59, 1'b1, BGC, -1, "r0_y");
        idle(4);
        pulse("msk_pre", 4'b0000);

        // priority and overlap
        set_obj(0, 100, 100, 20, RED, 1'b1, 1'b0);
        set_obj(2, 110, 100, 20, BLU, 1'b1, 1'b0);
        px(110, 100, 1'b1, RED, 0, "prio");
        px(125, 100, 1'b1, BLU, 2, "prio_b");
        px(80, 100, 1'b1, RED, 0, "prio_e0");
        px(130, 100, 1'b1, BLU, 2, "prio_e2");
        px(131, 100, 1'b1, BGC, -1, "prio_out");
        idle(4);
        obj_en[0] = 1'b0;
        px(110, 100, 1'b1, BLU, 2, "prio_dis");
        idle(4);
        pulse("ovl_set", 4'b0101);
        obj_en[0] = 1'b1;
        set_obj(2, 400, 400, 20, BLU, 1'b1, 1'b0);
        px(100, 100, 1'b1, RED, 0, "sep_0");
        px(400, 400, 1'b1, BLU, 2, "sep_2");
        px(110, 100, 1'b1, RED, 0, "sep_1");
        idle(4);
        pulse("ovl_clr", 4'b0000);

        // asynchronous reset with overlapping hits in flight
        set_obj(2, 110, 100, 20, BLU, 1'b1, 1'b0);
        idle(2);
        for (int k = 0; k < 5; k++) px(110, 100, 1'b1, RED, 0, "pre_rst");
        #2;
        Reset = 1'b1;
        pixel_valid = 1'b0;
        sb.delete();
        exp_px("rst_mid", 0, 1'b0, 24'h0, -1);
        exp_mask("rst_msk", 0, '0);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        px(110, 100, 1'b1, RED, 0, "post_rst");
        idle(5);
        exp_mask("msk_hold", 0, '0);
        pulse("msk_post", 4'b0101);

        // blink with a two-frame half period; obj3 never blinks
        idle(4);
        obj_en = '0; obj_blink = '0;
        reset_dut();
        set_obj(1, 200, 200, 5, GRN, 1'b1, 1'b1);
        set_obj(3, 300, 300, 5, BLU, 1'b1, 1'b0);
        for (int f = 0; f < 6; f++) begin
            if (((f / 2) % 2) == 0) px(200, 200, 1'b1, GRN, 1, "blink_on");
            else                    px(200, 200, 1'b1, BGC, -1, "blink_off");
            px(300, 300, 1'b1, BLU, 3, "steady");
            idle(4);
            pulse("blink_m", 4'b0000);
        end

        for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge Clk);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations never sampled", sb.size());
            n_checks += sb.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
